// File: rtl/core_csr.sv
`default_nettype none
// ============================================================================
// Module      : core_csr
// Description : Machine-mode CSR register file for the rv32i core.
//               Combinational reads (with same-cycle write bypass), two write
//               sources (execute stage, interrupt sequencer; sequencer wins on
//               an address collision), free-running 64-bit mcycle counter.
// Optional    : `define CORE_CSR_INSTRET_EN adds minstret/minstreth
//               (0xB02/0xB82) and read-only aliases instret/instreth
//               (0xC02/0xC82), counting cycles with retire_i=1.
// Ports       : clk_i          core clock
//               rst_n_i        asynchronous active-low reset
//               rd_addr_i      CSR read address ([31:12] must be 0)
//               rd_data_o      CSR read data (combinational)
//               ex_waddr_i / ex_we_i / ex_wdata_i     execute-stage write
//               int_waddr_i / int_we_i / int_wdata_i  sequencer write
//               retire_i       instruction retired (optional feature only)
//               csr_mtvec_o / csr_mepc_o / csr_mstatus_o  registered CSRs
// Revision    : 1.0 - initial release
// ============================================================================
module core_csr #(
  parameter logic [31:0] HART_ID    = 32'h0,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RST  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] rd_addr_i,
  output logic [31:0] rd_data_o,
  input  logic [31:0] ex_waddr_i,
  input  logic        ex_we_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [31:0] int_waddr_i,
  input  logic        int_we_i,
  input  logic [31:0] int_wdata_i,
  input  logic        retire_i,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mstatus_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
`ifdef CORE_CSR_INSTRET_EN
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

  // Merge both write ports for one CSR: {write_enable, write_data}.
  // A full 32-bit compare also rejects any address with [31:12] != 0.
  // On a collision the sequencer data wins.
  function automatic logic [32:0] pick(
    input logic        ex_we,
    input logic [31:0] ex_addr,
    input logic [31:0] ex_data,
    input logic        int_we,
    input logic [31:0] int_addr,
    input logic [31:0] int_data,
    input logic [11:0] csr
  );
    logic int_hit;
    logic ex_hit;
    int_hit = int_we && (int_addr == {20'h0, csr});
    ex_hit  = ex_we  && (ex_addr  == {20'h0, csr});
    if (int_hit)     pick = {1'b1, int_data};
    else if (ex_hit) pick = {1'b1, ex_data};
    else             pick = {1'b0, 32'h0};
  endfunction

  // mstatus is stored as {SINT, MPIE, MIE}; MPP is hard-wired to 2'b11.
  function automatic logic [31:0] mstatus_view(input logic [2:0] b);
    mstatus_view = {b[2], 18'h0, 2'b11, 3'b000, b[1], 3'b000, b[0], 3'b000};
  endfunction

  logic [32:0] w_mstatus;
  logic [32:0] w_mie;
  logic [32:0] w_mtvec;
  logic [32:0] w_mscratch;
  logic [32:0] w_mepc;
  logic [32:0] w_mcause;
  logic [32:0] w_mcycle;
  logic [32:0] w_mcycleh;

  assign w_mstatus  = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MSTATUS);
  assign w_mie      = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MIE);
  assign w_mtvec    = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MTVEC);
  assign w_mscratch = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MSCRATCH);
  assign w_mepc     = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MEPC);
  assign w_mcause   = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MCAUSE);
  assign w_mcycle   = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MCYCLE);
  assign w_mcycleh  = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MCYCLEH);

  // Field-masked next values, shared by the register update and read bypass
  logic [2:0]  mstatus_nxt;
  logic [31:0] mepc_nxt;
  assign mstatus_nxt = {w_mstatus[31], w_mstatus[7], w_mstatus[3]};
  assign mepc_nxt    = {w_mepc[31:2], 2'b00};

  logic [2:0]  mstatus_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mcycle_lo_q;
  logic [31:0] mcycle_hi_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mstatus_q  <= 3'b000;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
    end else begin
      if (w_mstatus[32])  mstatus_q  <= mstatus_nxt;
      if (w_mie[32])      mie_q      <= w_mie[31:0];
      if (w_mtvec[32])    mtvec_q    <= w_mtvec[31:0];
      if (w_mscratch[32]) mscratch_q <= w_mscratch[31:0];
      if (w_mepc[32])     mepc_q     <= mepc_nxt;
      if (w_mcause[32])   mcause_q   <= w_mcause[31:0];
    end
  end

  // A write to either half suppresses the whole increment, so the unwritten
  // half holds and no carry is generated on that cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcycle_lo_q <= 32'h0;
      mcycle_hi_q <= 32'h0;
    end else if (w_mcycle[32] || w_mcycleh[32]) begin
      if (w_mcycle[32])  mcycle_lo_q <= w_mcycle[31:0];
      if (w_mcycleh[32]) mcycle_hi_q <= w_mcycleh[31:0];
    end else begin
      {mcycle_hi_q, mcycle_lo_q} <= {mcycle_hi_q, mcycle_lo_q} + 64'd1;
    end
  end

`ifdef CORE_CSR_INSTRET_EN
  logic [32:0] w_minstret;
  logic [32:0] w_minstreth;
  logic [31:0] minstret_lo_q;
  logic [31:0] minstret_hi_q;

  assign w_minstret  = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MINSTRET);
  assign w_minstreth = pick(ex_we_i, ex_waddr_i, ex_wdata_i, int_we_i, int_waddr_i, int_wdata_i, ADDR_MINSTRETH);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      minstret_lo_q <= 32'h0;
      minstret_hi_q <= 32'h0;
    end else if (w_minstret[32] || w_minstreth[32]) begin
      if (w_minstret[32])  minstret_lo_q <= w_minstret[31:0];
      if (w_minstreth[32]) minstret_hi_q <= w_minstreth[31:0];
    end else if (retire_i) begin
      {minstret_hi_q, minstret_lo_q} <= {minstret_hi_q, minstret_lo_q} + 64'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  // Read mux: writable CSRs bypass the pending write; read-only aliases and
  // constants always return their stored/fixed value.
  always_comb begin
    rd_data_o = 32'h0;
    if (rd_addr_i[31:12] == 20'h0) begin
      case (rd_addr_i[11:0])
        ADDR_MSTATUS:  rd_data_o = mstatus_view(w_mstatus[32] ? mstatus_nxt : mstatus_q);
        ADDR_MISA:     rd_data_o = MISA_VALUE;
        ADDR_MIE:      rd_data_o = w_mie[32]      ? w_mie[31:0]      : mie_q;
        ADDR_MTVEC:    rd_data_o = w_mtvec[32]    ? w_mtvec[31:0]    : mtvec_q;
        ADDR_MSCRATCH: rd_data_o = w_mscratch[32] ? w_mscratch[31:0] : mscratch_q;
        ADDR_MEPC:     rd_data_o = w_mepc[32]     ? mepc_nxt         : mepc_q;
        ADDR_MCAUSE:   rd_data_o = w_mcause[32]   ? w_mcause[31:0]   : mcause_q;
        ADDR_MCYCLE:   rd_data_o = w_mcycle[32]   ? w_mcycle[31:0]   : mcycle_lo_q;
        ADDR_MCYCLEH:  rd_data_o = w_mcycleh[32]  ? w_mcycleh[31:0]  : mcycle_hi_q;
        ADDR_CYCLE:    rd_data_o = mcycle_lo_q;
        ADDR_CYCLEH:   rd_data_o = mcycle_hi_q;
        ADDR_MHARTID:  rd_data_o = HART_ID;
`ifdef CORE_CSR_INSTRET_EN
        ADDR_MINSTRET:  rd_data_o = w_minstret[32]  ? w_minstret[31:0]  : minstret_lo_q;
        ADDR_MINSTRETH: rd_data_o = w_minstreth[32] ? w_minstreth[31:0] : minstret_hi_q;
        ADDR_INSTRET:   rd_data_o = minstret_lo_q;
        ADDR_INSTRETH:  rd_data_o = minstret_hi_q;
`endif
        default:       rd_data_o = 32'h0;
      endcase
    end
  end

  assign csr_mtvec_o   = mtvec_q;
  assign csr_mepc_o    = mepc_q;
  assign csr_mstatus_o = mstatus_view(mstatus_q);

endmodule
`default_nettype wire

// File: tb/tb_core_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_csr
// Description : Self-checking bench for core_csr. Table-driven vectors for
//               the register map, masking, priority and bypass; hand-written
//               sequences for counter wrap/carry, instret and async reset.
//               Honours CORE_CSR_INSTRET_EN for the optional counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_csr;

  logic        clk;
  logic        rst_n;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [31:0] ex_waddr;
  logic        ex_we;
  logic [31:0] ex_wdata;
  logic [31:0] int_waddr;
  logic        int_we;
  logic [31:0] int_wdata;
  logic        retire;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic [31:0] mstatus_o;

  core_csr dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .ex_waddr_i    (ex_waddr),
    .ex_we_i       (ex_we),
    .ex_wdata_i    (ex_wdata),
    .int_waddr_i   (int_waddr),
    .int_we_i      (int_we),
    .int_wdata_i   (int_wdata),
    .retire_i      (retire),
    .csr_mtvec_o   (mtvec_o),
    .csr_mepc_o    (mepc_o),
    .csr_mstatus_o (mstatus_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ex_we;
    logic [31:0] ex_a;
    logic [31:0] ex_d;
    logic        int_we;
    logic [31:0] int_a;
    logic [31:0] int_d;
    logic [31:0] rd_a;
    logic [31:0] exp_rd;
    logic        chk;
    logic [31:0] exp_ms;
    logic [31:0] exp_mt;
    logic [31:0] exp_me;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] exp_rd;
    logic        chk;
    logic [31:0] exp_ms;
    logic [31:0] exp_mt;
    logic [31:0] exp_me;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef CORE_CSR_INSTRET_EN
  localparam logic [31:0] INSTRET_77 = 32'h77;
`else
  localparam logic [31:0] INSTRET_77 = 32'h0;
`endif

  function automatic vec_t mk(
    input logic ex_we_v, input logic [31:0] ex_a, input logic [31:0] ex_d,
    input logic int_we_v, input logic [31:0] int_a, input logic [31:0] int_d,
    input logic [31:0] rd_a, input logic [31:0] exp_rd,
    input logic chk, input logic [31:0] ms, input logic [31:0] mt, input logic [31:0] me
  );
    vec_t v;
    v.ex_we = ex_we_v;   v.ex_a = ex_a;   v.ex_d = ex_d;
    v.int_we = int_we_v; v.int_a = int_a; v.int_d = int_d;
    v.rd_a = rd_a; v.exp_rd = exp_rd;
    v.chk = chk; v.exp_ms = ms; v.exp_mt = mt; v.exp_me = me;
    return v;
  endfunction

  // Read-only cycle with no registered-output check
  function automatic vec_t rd(input logic [31:0] a, input logic [31:0] e);
    return mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, a, e, 1'b0, 32'h0, 32'h0, 32'h0);
  endfunction

  // Single execute-stage write with a read in the same cycle
  function automatic vec_t exw(input logic [31:0] wa, input logic [31:0] wd,
                               input logic [31:0] a, input logic [31:0] e);
    return mk(1'b1, wa, wd, 1'b0, 32'h0, 32'h0, a, e, 1'b0, 32'h0, 32'h0, 32'h0);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one cycle (inputs just after posedge), queue the expectation,
  // compare at the following negedge, then advance past the next posedge.
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    ex_we = v.ex_we;   ex_waddr = v.ex_a;   ex_wdata = v.ex_d;
    int_we = v.int_we; int_waddr = v.int_a; int_wdata = v.int_d;
    rd_addr = v.rd_a;
    e.id = id; e.exp_rd = v.exp_rd; e.chk = v.chk;
    e.exp_ms = v.exp_ms; e.exp_mt = v.exp_mt; e.exp_me = v.exp_me;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty vec%0d: got 0 entries expected 1", id);
    end else begin
      e = sb.pop_front();
      check32($sformatf("vec%0d rd_data", e.id), rd_data, e.exp_rd);
      if (e.chk) begin
        check32($sformatf("vec%0d csr_mstatus", e.id), mstatus_o, e.exp_ms);
        check32($sformatf("vec%0d csr_mtvec", e.id), mtvec_o, e.exp_mt);
        check32($sformatf("vec%0d csr_mepc", e.id), mepc_o, e.exp_me);
      end
    end
    @(posedge clk);
    #1;
    ex_we = 1'b0;
    int_we = 1'b0;
  endtask

  vec_t tbl[23];

  initial begin
    rst_n = 1'b0;
    rd_addr = 32'h0;
    ex_we = 1'b0;  ex_waddr = 32'h0;  ex_wdata = 32'h0;
    int_we = 1'b0; int_waddr = 32'h0; int_wdata = 32'h0;
    retire = 1'b0;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 32'h300, 32'h0000_1800, 1, 32'h0000_1800, 32'h0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 32'h301, 32'h4000_0100, 1, 32'h0000_1800, 32'h0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 32'hF14, 32'h0,         1, 32'h0000_1800, 32'h0, 32'h0);
    tbl[3]  = rd(32'h304, 32'h0);
    tbl[4]  = mk(1, 32'h300, 32'hFFFF_FFFF, 0, 0, 0, 32'h300, 32'h8000_1888, 1, 32'h0000_1800, 32'h0, 32'h0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 32'h300, 32'h8000_1888, 1, 32'h8000_1888, 32'h0, 32'h0);
    tbl[6]  = mk(1, 32'h341, 32'h5555_5555, 1, 32'h341, 32'h0000_1237, 32'h341, 32'h0000_1234,
                 1, 32'h8000_1888, 32'h0, 32'h0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 32'h341, 32'h0000_1234, 1, 32'h8000_1888, 32'h0, 32'h0000_1234);
    tbl[8]  = mk(1, 32'h340, 32'hA5A5_A5A5, 1, 32'h342, 32'h8000_0003, 32'h342, 32'h8000_0003,
                 0, 32'h0, 32'h0, 32'h0);
    tbl[9]  = rd(32'h340, 32'hA5A5_A5A5);
    tbl[10] = rd(32'h342, 32'h8000_0003);
    tbl[11] = mk(1, 32'h305, 32'h0000_0100, 0, 0, 0, 32'h305, 32'h0000_0100, 1, 32'h8000_1888, 32'h0, 32'h0000_1234);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h8000_1888, 32'h0000_0100, 32'h0000_1234);
    tbl[13] = exw(32'h0000_1304, 32'hDEAD_BEEF, 32'h304, 32'h0);
    tbl[14] = rd(32'h304, 32'h0);
    tbl[15] = exw(32'h304, 32'h0000_0888, 32'h304, 32'h0000_0888);
    tbl[16] = mk(0, 0, 0, 1, 32'h301, 32'h0, 32'h301, 32'h4000_0100, 0, 32'h0, 32'h0, 32'h0);
    tbl[17] = exw(32'hB02, 32'h77, 32'hB02, INSTRET_77);
    tbl[18] = rd(32'hB02, INSTRET_77);
    tbl[19] = mk(1, 32'h300, 32'hFFFF_FFFF, 1, 32'h300, 32'h0000_0008, 32'h300, 32'h0000_1808,
                 1, 32'h8000_1888, 32'h0000_0100, 32'h0000_1234);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 32'h300, 32'h0000_1808, 1, 32'h0000_1808, 32'h0000_0100, 32'h0000_1234);
    tbl[21] = rd(32'h304, 32'h0000_0888);
    tbl[22] = exw(32'h343, 32'hFFFF_FFFF, 32'h343, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) apply(tbl[i], i);

    // mcycle: load near the top, wrap through all-ones to zero
    apply(exw(32'hB00, 32'hFFFF_FFFE, 32'hB00, 32'hFFFF_FFFE), 100);
    apply(exw(32'hB80, 32'hFFFF_FFFF, 32'hB00, 32'hFFFF_FFFE), 101);
    apply(rd(32'hC80, 32'hFFFF_FFFF), 102);
    apply(rd(32'hB00, 32'hFFFF_FFFF), 103);
    apply(rd(32'hB80, 32'h0), 104);
    apply(rd(32'hC00, 32'h1), 105);

    // Carry into the high word only on a non-write cycle
    apply(exw(32'hB80, 32'h5, 32'hB80, 32'h5), 110);
    apply(exw(32'hB00, 32'hFFFF_FFFF, 32'hB80, 32'h5), 111);
    apply(rd(32'hB00, 32'hFFFF_FFFF), 112);
    apply(rd(32'hB80, 32'h6), 113);
    apply(rd(32'hB00, 32'h1), 114);

    // Retire counter: five pulses over ten cycles
    apply(exw(32'hB02, 32'h0, 32'h0, 32'h0), 120);
    for (int i = 0; i < 10; i++) begin
      retire = (i % 2 == 0);
      apply(rd(32'h0, 32'h0), 121 + i);
    end
    retire = 1'b0;
`ifdef CORE_CSR_INSTRET_EN
    apply(rd(32'hB02, 32'h5), 131);
    apply(rd(32'hC02, 32'h5), 132);
    apply(rd(32'hB82, 32'h0), 133);
`else
    apply(rd(32'hB02, 32'h0), 131);
    apply(rd(32'hC02, 32'h0), 132);
`endif

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    rd_addr = 32'h340;
    #1;
    check32("async_rst mscratch", rd_data, 32'h0);
    rd_addr = 32'hB00;
    #1;
    check32("async_rst mcycle", rd_data, 32'h0);
    check32("async_rst csr_mstatus", mstatus_o, 32'h0000_1800);
    check32("async_rst csr_mtvec", mtvec_o, 32'h0);
    check32("async_rst csr_mepc", mepc_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(rd(32'hB00, 32'h0), 140);
    apply(rd(32'hB00, 32'h1), 141);
    apply(rd(32'hC00, 32'h2), 142);
    apply(rd(32'h300, 32'h0000_1800), 143);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
